module_de_bounce: RTL and testbench



---
 rtl/module_de_bounce.sv | 82 ++++++++
 tb/tb_module_de_bounce.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/module_de_bounce.sv
// Push-button debouncer: two-flop synchronizer, stable-high/stable-low run counters,
// and an arm flag so each press gives exactly one single-cycle DB_out pulse.
module module_de_bounce #(
  parameter int N         = 10,
  parameter int N_INHIBIT = 20
) (
  input  logic clk,
  input  logic n_reset,
  input  logic button_in,
  output logic DB_out
);

  localparam int SYNC_STAGES = 2;
  localparam int HW = $clog2(N + 1);
  localparam int LW = $clog2(N_INHIBIT + 1);

  localparam logic [HW-1:0] HIGH_MAX  = HW'(N);
  localparam logic [HW-1:0] HIGH_EDGE = HW'(N - 1);
  localparam logic [LW-1:0] LOW_MAX   = LW'(N_INHIBIT);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_in;

  logic [HW-1:0] high_cnt_reg;
  logic [HW-1:0] high_cnt_next;
  logic [LW-1:0] low_cnt_reg;
  logic [LW-1:0] low_cnt_next;
  logic          armed_reg;
  logic          armed_next;
  logic          db_out_reg;
  logic          pulse;

  // Stage 0 captures the raw pin; the last stage is the only level the counters see.
  always_ff @(posedge clk) begin
    if (n_reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], button_in};
    end
  end

  assign sync_in = sync_reg[SYNC_STAGES-1];

  always_comb begin
    high_cnt_next = '0;
    low_cnt_next  = '0;
    if (sync_in) begin
      high_cnt_next = (high_cnt_reg == HIGH_MAX) ? HIGH_MAX : high_cnt_reg + 1'b1;
    end else begin
      low_cnt_next = (low_cnt_reg == LOW_MAX) ? LOW_MAX : low_cnt_reg + 1'b1;
    end
  end

  // Only the N-1 -> N step fires, so a held button that sits at saturation never repeats.
  assign pulse = armed_reg && (high_cnt_reg == HIGH_EDGE) && (high_cnt_next == HIGH_MAX);

  always_comb begin
    armed_next = armed_reg;
    if (low_cnt_reg == LOW_MAX) begin
      armed_next = 1'b1;
    end else if (pulse) begin
      armed_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (n_reset) begin
      high_cnt_reg <= '0;
      low_cnt_reg  <= '0;
      armed_reg    <= 1'b1;
      db_out_reg   <= 1'b0;
    end else begin
      high_cnt_reg <= high_cnt_next;
      low_cnt_reg  <= low_cnt_next;
      armed_reg    <= armed_next;
      db_out_reg   <= pulse;
    end
  end

  assign DB_out = db_out_reg;

endmodule

// File: tb/tb_module_de_bounce.sv
// Randomized bench for module_de_bounce: a history-based reference model predicts
// DB_out every cycle, and directed phases check pulse counts and latency.
module tb_module_de_bounce;

  localparam int N         = 10;
  localparam int N_INHIBIT = 20;

  logic clk       = 1'b0;
  logic n_reset   = 1'b1;
  logic button_in = 1'b0;
  logic DB_out;

  module_de_bounce #(.N(N), .N_INHIBIT(N_INHIBIT)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .button_in (button_in),
    .DB_out    (DB_out)
  );

  initial forever #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: keeps the whole synchronized-level history since the last
  // reset and derives each pulse from run lengths in that history.
  bit sq[$];
  bit prev_b     = 1'b0;
  bit exp_db     = 1'b0;
  int last_pulse = -1;
  int m_t, m_run, m_zero;
  bit m_armed;

  always @(posedge clk) begin
    if (n_reset) begin
      sq.delete();
      sq.push_back(1'b0);
      last_pulse = -1;
      exp_db     = 1'b0;
    end else begin
      m_t   = sq.size();
      m_run = 0;
      for (int k = m_t - 1; k >= 0 && sq[k]; k--) m_run++;
      m_armed = (last_pulse < 0);
      if (!m_armed) begin
        m_zero = 0;
        for (int k = last_pulse; k < m_t; k++) begin
          m_zero = sq[k] ? 0 : m_zero + 1;
          if (m_zero >= N_INHIBIT) m_armed = 1'b1;
        end
      end
      exp_db = (m_run == N) && m_armed;
      if (exp_db) last_pulse = m_t;
      sq.push_back((m_t >= 2) ? prev_b : 1'b0);
    end
    prev_b = button_in;
  end

  always @(negedge clk) check("db_out", DB_out, exp_db);

  int cyc = 0;
  int phase_pulses = 0;
  int first_pulse_cyc = -1;
  int mark;

  // One cycle of stimulus, driven at the falling edge; optional glitch stays
  // well clear of the next rising edge so the synchronizer never sees it.
  task automatic step(input logic lvl, input bit glitch, input logic rst);
    @(negedge clk);
    cyc++;
    if (DB_out === 1'b1) begin
      phase_pulses++;
      if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
    end
    n_reset   = rst;
    button_in = lvl;
    if (glitch && $urandom_range(0, 1) == 1) begin
      #1 button_in = ~lvl;
      #2 button_in = lvl;
    end
  endtask

  task automatic hold(input logic lvl, input int n, input bit glitch, input logic rst);
    for (int i = 0; i < n; i++) step(lvl, glitch, rst);
  endtask

  task automatic phase_start();
    phase_pulses    = 0;
    first_pulse_cyc = -1;
  endtask

  initial begin
    int len;
    logic lvl;

    phase_start();
    for (int i = 0; i < 3; i++) step(logic'($urandom_range(0, 1)), 1'b1, 1'b1);
    check("rst_db_out", DB_out, 0);
    check("rst_high_cnt", dut.high_cnt_reg, 0);
    check("rst_low_cnt", dut.low_cnt_reg, 0);
    check("rst_armed", dut.armed_reg, 1);
    check("rst_pulses", phase_pulses, 0);
    $display("phase reset: pulses=%0d", phase_pulses);
    hold(1'b0, 5, 1'b0, 1'b0);

    phase_start();
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, $urandom_range(1, N - 1), 1'b1, 1'b0);
      hold(1'b0, $urandom_range(1, 3), 1'b1, 1'b0);
    end
    hold(1'b0, 10, 1'b1, 1'b0);
    check("bounce_pulses", phase_pulses, 0);
    $display("phase short bounce: pulses=%0d", phase_pulses);

    phase_start();
    hold(1'b1, 1, 1'b0, 1'b0);
    mark = cyc;
    hold(1'b1, 54, 1'b1, 1'b0);
    check("press_pulses", phase_pulses, 1);
    check("press_latency", first_pulse_cyc - mark, N + 2);
    $display("phase genuine press: pulses=%0d latency=%0d", phase_pulses, first_pulse_cyc - mark);

    phase_start();
    for (int i = 0; i < 4; i++) begin
      hold(1'b0, $urandom_range(1, 2), 1'b0, 1'b0);
      hold(1'b1, 1, 1'b0, 1'b0);
    end
    hold(1'b0, 10, 1'b0, 1'b0);
    hold(1'b1, 20, 1'b0, 1'b0);
    check("early_repress_pulses", phase_pulses, 0);
    $display("phase early re-press: pulses=%0d", phase_pulses);

    phase_start();
    hold(1'b0, 80, 1'b1, 1'b0);
    hold(1'b1, 1, 1'b0, 1'b0);
    mark = cyc;
    hold(1'b1, 49, 1'b0, 1'b0);
    check("rearm_pulses", phase_pulses, 1);
    check("rearm_latency", first_pulse_cyc - mark, N + 2);
    $display("phase re-arm: pulses=%0d latency=%0d", phase_pulses, first_pulse_cyc - mark);

    hold(1'b0, 30, 1'b0, 1'b0);
    phase_start();
    hold(1'b1, 7, 1'b0, 1'b0);
    hold(1'b1, $urandom_range(1, 3), 1'b0, 1'b1);
    check("midreset_aborted", phase_pulses, 0);
    phase_start();
    hold(1'b1, 1, 1'b0, 1'b0);
    mark = cyc;
    hold(1'b1, 30, 1'b0, 1'b0);
    check("midreset_pulses", phase_pulses, 1);
    check("midreset_latency", first_pulse_cyc - mark, N + 2);
    $display("phase reset mid-count: pulses=%0d latency=%0d", phase_pulses, first_pulse_cyc - mark);

    phase_start();
    for (int i = 0; i < 80; i++) begin
      lvl = logic'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? N - 1 + $urandom_range(0, 2) : $urandom_range(1, 30);
      hold(lvl, len, bit'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 15) == 0) hold(lvl, $urandom_range(1, 2), 1'b0, 1'b1);
    end
    hold(1'b0, 5, 1'b0, 1'b0);
    $display("phase random: pulses=%0d cycles=%0d", phase_pulses, cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
